lsu_byte_master: RTL
====================

Name: lsu_byte_master

Overview:
- Load/store initiator between the pipeline MEM stage and a byte-wide, little-endian data memory port.
- Accepts one 32-bit word load or store per request over a valid/ready handshake.
- Performs the access as four sequential byte beats at addr, addr+1, addr+2, addr+3.
- Returns one response per request, carrying the assembled load word or a write acknowledge, plus an error flag.

Parameters:
- MEM_BYTES, 32: size of the data memory in bytes. A request whose addr+3 >= MEM_BYTES is out of range.
- ADDR_W, 32: width of the request and memory address buses.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request; high only in IDLE.
- req_write_i  input  1  1 = store word, 0 = load word.
- req_addr_i  input  ADDR_W  byte address of the word.
- req_wdata_i  input  32  store data.
- rsp_valid_o  output  1  one-cycle response strobe.
- rsp_write_o  output  1  echo of the request type.
- rsp_err_o  output  1  misaligned or out-of-range request; no memory access was made.
- rsp_rdata_o  output  32  load result; 0 for stores and errors.
- busy_o  output  1  high whenever state != IDLE; used as the pipeline stall.
- mem_addr_o  output  ADDR_W  byte address of the current beat.
- mem_wdata_o  output  8  byte being written.
- mem_read_o  output  1  byte read strobe.
- mem_write_o  output  1  byte write strobe; memory captures on the clock edge.
- mem_rdata_i  input  8  byte read data, combinationally valid in the same cycle as mem_addr_o/mem_read_o.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, beat counter=0.
  - req_ready_o=1; rsp_valid_o, rsp_write_o, rsp_err_o, busy_o, mem_read_o, mem_write_o all 0.
  - mem_addr_o=0, mem_wdata_o=0, rsp_rdata_o=0, internal data/address registers=0.
- States:
  - IDLE: req_ready_o=1, no memory strobes. On req_valid_i=1:
    - Capture addr, wdata and write into registers.
    - If addr[1:0]!=0 or addr+3 >= MEM_BYTES: go to RESP with err=1.
    - Otherwise go to XFER with beat=0 and clear the read accumulator.
  - XFER, beat k = 0..3:
    - mem_addr_o = base+k.
    - Load: mem_read_o=1. The accumulator byte [8k+7:8k] takes mem_rdata_i at the end of the cycle.
    - Store: mem_write_o=1, mem_wdata_o = wdata[8k+7:8k].
    - Exactly one of mem_read_o/mem_write_o is high per beat.
    - After beat 3, go to RESP.
  - RESP:
    - rsp_valid_o=1 for exactly one cycle.
    - rsp_rdata_o = accumulator for a load without error, else 0.
    - rsp_err_o and rsp_write_o as captured.
    - Next state is IDLE.
- Latency:
  - Valid request: accept at cycle 0, beats at cycles 1–4, response at cycle 5, next accept possible at cycle 6.
  - Error request: response at cycle 1.
- Input handling:
  - Request inputs are sampled only at the accept edge; changes while busy are ignored.
  - The response has no backpressure; the consumer must take it in the RESP cycle.
  - In IDLE and RESP, mem_* outputs hold 0 (address/data driven to 0, not X).
- Address arithmetic: base+k is computed at ADDR_W bits. No wrap is possible because of the range check.
- Reset during XFER:
  - Abort immediately; strobes drop asynchronously.
  - No response is issued.
  - A store may leave memory partially updated. This is accepted, not repaired.
- Simultaneous events: req_valid_i is high in RESP → not accepted (ready=0); it is taken in the following IDLE cycle.

Decomposition:
- Shared package (lsu_pkg):
  - State encoding enum: IDLE=2'd0, XFER=2'd1, RESP=2'd2.
  - BYTES_PER_WORD=4.
  - Beat counter width 2.
- One sub-module is natural: lsu_byte_packer.
  - Combinational byte select for store data by beat index.
  - Byte-lane insert into the load accumulator.
  - The FSM and counters stay in the top module.

Test Plan:
- Store 0xDEADBEEF at addr 8:
  - mem_write_o high cycles 1–4, addr 8,9,10,11, wdata EF,BE,AD,DE.
  - Cycle 5: rsp_valid_o=1, rsp_write_o=1, rsp_err_o=0, rsp_rdata_o=0.
- Load from addr 8 after the above store (behavioural byte memory model):
  - mem_read_o high 4 cycles.
  - Cycle 5: rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
- Load from addr 6 (misaligned): no mem_read_o/mem_write_o ever; cycle 1: rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
- Store to addr 32 with MEM_BYTES=32: no memory strobes; rsp_err_o=1 at cycle 1. Also store to addr 28: accepted, beats at addr 28–31.
- Back-to-back requests, req_valid_i held high: accepts occur exactly 6 cycles apart; req_ready_o=0 and busy_o=1 during cycles 1–5.
- rst_i pulsed low during beat 2 of a store:
  - All strobes 0 immediately, req_ready_o=1, no rsp_valid_o.
  - Memory holds new bytes only at addr+0 and addr+1.
  - The next request completes normally.

Source files
------------

// File: rtl/lsu_byte_master_pkg.sv
// rtl/lsu_byte_master_pkg.sv - shared state encoding and beat constants for the byte-wide LSU
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BEAT_W         = 2;

  // Index of the final byte beat of a word access
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/lsu_byte_master_if.sv
// rtl/lsu_byte_master_if.sv - request, response and byte-memory signals of the LSU
interface lsu_byte_master_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;

  logic              rsp_valid_o;
  logic              rsp_write_o;
  logic              rsp_err_o;
  logic [31:0]       rsp_rdata_o;

  logic              busy_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [7:0]        mem_rdata_i;

  // LSU side: drives requests out to memory and responses back to the pipeline
  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_write_o, rsp_err_o, rsp_rdata_o,
    output busy_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );

  // Environment side: pipeline plus data memory
  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_write_o, rsp_err_o, rsp_rdata_o,
    input  busy_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
  );

endinterface

// File: rtl/lsu_byte_master_packer.sv
// rtl/lsu_byte_master_packer.sv - store byte select and load byte-lane insert
module lsu_byte_packer
  import lsu_pkg::*;
(
  input  logic [31:0]       wdata,
  input  logic [BEAT_W-1:0] wsel,
  output logic [7:0]        wbyte,
  input  logic [31:0]       acc,
  input  logic [BEAT_W-1:0] lane,
  input  logic [7:0]        rbyte,
  output logic [31:0]       acc_next
);

  // Little-endian lanes: beat k carries bits [8k+7:8k]
  always_comb begin
    wbyte                        = wdata[{wsel, 3'b000} +: 8];
    acc_next                     = acc;
    acc_next[{lane, 3'b000} +: 8] = rbyte;
  end

endmodule

// File: rtl/lsu_byte_master.sv
// rtl/lsu_byte_master.sv - word load/store initiator issuing four byte beats to a byte-wide memory
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  lsu_byte_master_if.master bus
);

  lsu_state_t        state;
  logic [BEAT_W-1:0] beat;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic              write_q;
  logic [31:0]       acc_q;

  logic [ADDR_W:0]   last_byte;
  logic              req_err;
  logic [BEAT_W-1:0] next_beat;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       pk_wdata;
  logic [BEAT_W-1:0] pk_sel;
  logic [7:0]        pk_wbyte;
  logic [31:0]       acc_next;

  // Request legality; one extra bit keeps addr+3 from wrapping past the top of the address space
  always_comb begin
    last_byte = {1'b0, bus.req_addr_i} + (ADDR_W+1)'(BYTES_PER_WORD - 1);
    req_err   = (bus.req_addr_i[1:0] != 2'b00) ||
                (last_byte >= (ADDR_W+1)'(MEM_BYTES));
  end

  // Next-beat address and store byte source; in IDLE the incoming request supplies beat 0
  always_comb begin
    next_beat = beat + BEAT_W'(1);
    next_addr = base_q + ADDR_W'(next_beat);
    if (state == IDLE) begin
      pk_wdata = bus.req_wdata_i;
      pk_sel   = '0;
    end else begin
      pk_wdata = wdata_q;
      pk_sel   = next_beat;
    end
  end

  lsu_byte_packer u_packer (
    .wdata    (pk_wdata),
    .wsel     (pk_sel),
    .wbyte    (pk_wbyte),
    .acc      (acc_q),
    .lane     (beat),
    .rbyte    (bus.mem_rdata_i),
    .acc_next (acc_next)
  );

  // Control FSM; every output is registered so beat k's strobes are stable for the whole cycle
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state           <= IDLE;
      beat            <= '0;
      base_q          <= '0;
      wdata_q         <= '0;
      write_q         <= 1'b0;
      acc_q           <= '0;
      bus.req_ready_o <= 1'b1;
      bus.busy_o      <= 1'b0;
      bus.rsp_valid_o <= 1'b0;
      bus.rsp_write_o <= 1'b0;
      bus.rsp_err_o   <= 1'b0;
      bus.rsp_rdata_o <= '0;
      bus.mem_addr_o  <= '0;
      bus.mem_wdata_o <= '0;
      bus.mem_read_o  <= 1'b0;
      bus.mem_write_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            base_q          <= bus.req_addr_i;
            wdata_q         <= bus.req_wdata_i;
            write_q         <= bus.req_write_i;
            bus.req_ready_o <= 1'b0;
            bus.busy_o      <= 1'b1;
            if (req_err) begin
              state           <= RESP;
              bus.rsp_valid_o <= 1'b1;
              bus.rsp_write_o <= bus.req_write_i;
              bus.rsp_err_o   <= 1'b1;
              bus.rsp_rdata_o <= '0;
            end else begin
              state           <= XFER;
              beat            <= '0;
              acc_q           <= '0;
              bus.mem_addr_o  <= bus.req_addr_i;
              bus.mem_read_o  <= !bus.req_write_i;
              bus.mem_write_o <= bus.req_write_i;
              bus.mem_wdata_o <= bus.req_write_i ? pk_wbyte : 8'h00;
            end
          end
        end

        XFER: begin
          if (!write_q) begin
            acc_q <= acc_next;
          end
          if (beat == LAST_BEAT) begin
            state           <= RESP;
            bus.mem_addr_o  <= '0;
            bus.mem_wdata_o <= '0;
            bus.mem_read_o  <= 1'b0;
            bus.mem_write_o <= 1'b0;
            bus.rsp_valid_o <= 1'b1;
            bus.rsp_write_o <= write_q;
            bus.rsp_err_o   <= 1'b0;
            bus.rsp_rdata_o <= write_q ? 32'h0 : acc_next;
          end else begin
            beat            <= next_beat;
            bus.mem_addr_o  <= next_addr;
            bus.mem_wdata_o <= write_q ? pk_wbyte : 8'h00;
          end
        end

        RESP: begin
          state           <= IDLE;
          bus.rsp_valid_o <= 1'b0;
          bus.rsp_write_o <= 1'b0;
          bus.rsp_err_o   <= 1'b0;
          bus.rsp_rdata_o <= '0;
          bus.req_ready_o <= 1'b1;
          bus.busy_o      <= 1'b0;
        end

        default: begin
          state           <= IDLE;
          beat            <= '0;
          bus.req_ready_o <= 1'b1;
          bus.busy_o      <= 1'b0;
          bus.rsp_valid_o <= 1'b0;
          bus.mem_read_o  <= 1'b0;
          bus.mem_write_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
